vmat_operand_loader: RTL



---
 rtl/vmat_operand_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vmat_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : vmat_operand_loader
// Brief    : Fetches two row-major VEC_COUNT x VEC_COUNT operand matrices
//            (A then B) one element per memory transaction and packs them
//            into the row arrays consumed by the matrix-multiply VALU.
// Revision : 1.0 - initial release
// ============================================================================
module vmat_operand_loader #(
    parameter int ELEM_WIDTH = 32,
    parameter int VEC_COUNT  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            start_i,
    input  logic [ADDR_WIDTH-1:0]                           base_a_i,
    input  logic [ADDR_WIDTH-1:0]                           base_b_i,
    output logic                                            busy_o,
    output logic                                            done_o,
    output logic                                            err_o,
    output logic                                            mem_req_o,
    output logic [ADDR_WIDTH-1:0]                           mem_addr_o,
    input  logic                                            mem_gnt_i,
    input  logic                                            mem_rvalid_i,
    input  logic [ELEM_WIDTH-1:0]                           mem_rdata_i,
    output logic [VEC_COUNT-1:0][ELEM_WIDTH*VEC_COUNT-1:0]  vec_a_o,
    output logic [VEC_COUNT-1:0][ELEM_WIDTH*VEC_COUNT-1:0]  vec_b_o
);

    localparam int c_N_TOTAL = 2 * VEC_COUNT * VEC_COUNT;
    localparam int c_NW      = (c_N_TOTAL > 1) ? $clog2(c_N_TOTAL) : 1;
    localparam int c_RW      = (VEC_COUNT > 1) ? $clog2(VEC_COUNT) : 1;

    localparam logic [ADDR_WIDTH-1:0] c_STRIDE   = ADDR_WIDTH'(ELEM_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ADDR_WIDTH'(ELEM_WIDTH / 8 - 1);
    localparam logic [c_NW-1:0]       c_LAST     = c_NW'(c_N_TOTAL - 1);
    localparam logic [c_RW-1:0]       c_DIM_LAST = c_RW'(VEC_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_base_a;
    logic [ADDR_WIDTH-1:0]   r_base_b;
    logic [ADDR_WIDTH-1:0]   r_off;
    logic [c_NW-1:0]         r_n;
    logic [c_RW-1:0]         r_row;
    logic [c_RW-1:0]         r_col;
    logic                    r_sel_b;
    logic                    r_err;
    logic                    w_misaligned;
    logic [ADDR_WIDTH-1:0]   w_base;
    logic [VEC_COUNT-1:0][ELEM_WIDTH*VEC_COUNT-1:0] r_vec_a;
    logic [VEC_COUNT-1:0][ELEM_WIDTH*VEC_COUNT-1:0] r_vec_b;

    assign w_misaligned = ((base_a_i & c_ALIGN_MASK) != '0) ||
                          ((base_b_i & c_ALIGN_MASK) != '0);
    assign w_base       = r_sel_b ? r_base_b : r_base_a;
    assign vec_a_o      = r_vec_a;
    assign vec_b_o      = r_vec_b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = w_misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = w_base + r_off;
                if (mem_gnt_i) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy_o = 1'b1;
                if (mem_rvalid_i) begin
                    w_state_nxt = (r_n == c_LAST) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                err_o       = r_err;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Row/column/offset are walked incrementally so no divider or multiplier
    // is needed to turn the element index into an array slot and address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_base_a <= '0;
            r_base_b <= '0;
            r_off    <= '0;
            r_n      <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_sel_b  <= 1'b0;
            r_err    <= 1'b0;
            r_vec_a  <= '0;
            r_vec_b  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_base_a <= base_a_i;
                        r_base_b <= base_b_i;
                        r_off    <= '0;
                        r_n      <= '0;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_sel_b  <= 1'b0;
                        r_err    <= w_misaligned;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (r_sel_b) begin
                            r_vec_b[r_row][int'(r_col)*ELEM_WIDTH +: ELEM_WIDTH] <= mem_rdata_i;
                        end else begin
                            r_vec_a[r_row][int'(r_col)*ELEM_WIDTH +: ELEM_WIDTH] <= mem_rdata_i;
                        end
                        r_n <= r_n + c_NW'(1);
                        if (r_col == c_DIM_LAST) begin
                            r_col <= '0;
                            if (r_row == c_DIM_LAST) begin
                                r_row   <= '0;
                                r_sel_b <= 1'b1;
                                r_off   <= '0;
                            end else begin
                                r_row <= r_row + c_RW'(1);
                                r_off <= r_off + c_STRIDE;
                            end
                        end else begin
                            r_col <= r_col + c_RW'(1);
                            r_off <= r_off + c_STRIDE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
